// File: rtl/controle_bloqueio_if.sv
// Signal bundle between the board pushbuttons, the lock FSM and the lockout supervisor.
// The slave modport is the supervisor's view; master is the board/lock side.
interface controle_bloqueio_if;
    logic       insere_in;
    logic       reabrir;
    logic       lock_falha;
    logic       lock_aberto;
    logic       insere_out;
    logic       lock_reset_n;
    logic       bloqueado;
    logic       aberto;
    logic [2:0] falhas;

    modport master (
        output insere_in, reabrir, lock_falha, lock_aberto,
        input  insere_out, lock_reset_n, bloqueado, aberto, falhas
    );

    modport slave (
        input  insere_in, reabrir, lock_falha, lock_aberto,
        output insere_out, lock_reset_n, bloqueado, aberto, falhas
    );
endinterface

// File: rtl/controle_bloqueio.sv
// Lockout supervisor for the six-digit combination lock: re-arm sequencing, insert gating,
// failure counting and timed lockout. Define DEBOUNCE_EN to add debounce filters on both buttons.
module controle_bloqueio #(
    parameter int unsigned MAX_FALHAS      = 32'd3,
    parameter int unsigned CICLOS_BLOQUEIO = 32'd500000000,
    parameter int unsigned CICLOS_REARME   = 32'd4,
    parameter int unsigned CICLOS_FILTRO   = 32'd500000
) (
    input  logic               clk,
    input  logic               reset,
    controle_bloqueio_if.slave bus
);
    typedef enum logic [2:0] {
        REARME   = 3'd0,
        ARMADO   = 3'd1,
        FALHOU   = 3'd2,
        BLOQUEIO = 3'd3,
        ABERTO   = 3'd4
    } estado_t;

    if (MAX_FALHAS < 32'd1 || MAX_FALHAS > 32'd7 || CICLOS_REARME < 32'd4 ||
        CICLOS_BLOQUEIO < 32'd1 || CICLOS_FILTRO < 32'd1) begin : g_param_invalido
        $error("controle_bloqueio: parameter out of range");
    end

    estado_t     state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  falhas_q, falhas_d;
    logic        seen_q, seen_d;
    logic        insere_out_q, insere_out_d;
    logic        lock_reset_n_q, lock_reset_n_d;
    logic        bloqueado_q, bloqueado_d;
    logic        aberto_q, aberto_d;
    logic        seen_eff;

    logic [1:0]  ins_sync_q;
    logic [1:0]  reab_sync_q;
    logic        ins_lvl;
    logic        reab_lvl;
    logic        reab_prev_q;
    logic        reab_pulse_q;

    // Two-flop synchronizers; buttons idle high, so reset to 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_sync_q  <= 2'b11;
            reab_sync_q <= 2'b11;
        end else begin
            ins_sync_q  <= {ins_sync_q[0], bus.insere_in};
            reab_sync_q <= {reab_sync_q[0], bus.reabrir};
        end
    end

`ifdef DEBOUNCE_EN
    logic [1:0]  filt_q;
    logic [31:0] filt_cnt_q [2];
    logic [1:0]  filt_raw;

    assign filt_raw = {reab_sync_q[1], ins_sync_q[1]};

    // Debounce: a new level is accepted only after CICLOS_FILTRO consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q        <= 2'b11;
            filt_cnt_q[0] <= 32'd0;
            filt_cnt_q[1] <= 32'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (filt_raw[i] == filt_q[i]) begin
                    filt_cnt_q[i] <= 32'd0;
                end else if (filt_cnt_q[i] >= CICLOS_FILTRO - 32'd1) begin
                    filt_q[i]     <= filt_raw[i];
                    filt_cnt_q[i] <= 32'd0;
                end else begin
                    filt_cnt_q[i] <= filt_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    assign ins_lvl  = filt_q[0];
    assign reab_lvl = filt_q[1];
`else
    assign ins_lvl  = ins_sync_q[1];
    assign reab_lvl = reab_sync_q[1];
`endif

    // Falling-edge detector on reabrir, registered into a one-cycle pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reab_prev_q  <= 1'b1;
            reab_pulse_q <= 1'b0;
        end else begin
            reab_prev_q  <= reab_lvl;
            reab_pulse_q <= reab_prev_q & ~reab_lvl;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register alongside it
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        falhas_d       = falhas_q;
        seen_d         = 1'b0;
        insere_out_d   = 1'b1;
        lock_reset_n_d = 1'b1;
        bloqueado_d    = 1'b0;
        aberto_d       = 1'b0;
        seen_eff       = (state_q == ARMADO) & seen_q;

        case (state_q)
            REARME: begin
                if (cnt_q >= CICLOS_REARME - 32'd1) begin
                    state_d = ARMADO;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ARMADO: begin
                cnt_d = 32'd0;
                if (bus.lock_falha) begin
                    state_d  = FALHOU;
                    falhas_d = (falhas_q == 3'd7) ? 3'd7 : falhas_q + 3'd1;
                end else if (bus.lock_aberto) begin
                    state_d  = ABERTO;
                    falhas_d = 3'd0;
                end else begin
                    state_d = ARMADO;
                end
            end
            FALHOU: begin
                cnt_d = 32'd0;
                if ({29'd0, falhas_q} >= MAX_FALHAS) begin
                    state_d = BLOQUEIO;
                end else if (reab_pulse_q) begin
                    state_d = REARME;
                end else begin
                    state_d = FALHOU;
                end
            end
            BLOQUEIO: begin
                if (cnt_q >= CICLOS_BLOQUEIO - 32'd1) begin
                    state_d  = REARME;
                    cnt_d    = 32'd0;
                    falhas_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ABERTO: begin
                cnt_d = 32'd0;
                if (reab_pulse_q) begin
                    state_d = REARME;
                end else begin
                    state_d = ABERTO;
                end
            end
            default: begin
                state_d = REARME;
                cnt_d   = 32'd0;
            end
        endcase

        // One low pulse on insere during the lock reset lets its edge bookkeeping clear
        case (state_d)
            REARME: begin
                lock_reset_n_d = 1'b0;
                if ((cnt_d >= 32'd1) && (cnt_d <= CICLOS_REARME - 32'd2)) begin
                    insere_out_d = 1'b0;
                end else begin
                    insere_out_d = 1'b1;
                end
            end
            ARMADO: begin
                seen_d       = seen_eff | ins_lvl;
                insere_out_d = ins_lvl | ~seen_eff;
            end
            BLOQUEIO: begin
                bloqueado_d = 1'b1;
            end
            ABERTO: begin
                aberto_d = 1'b1;
            end
            default: begin
                insere_out_d = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= REARME;
            cnt_q          <= 32'd0;
            falhas_q       <= 3'd0;
            seen_q         <= 1'b0;
            insere_out_q   <= 1'b1;
            lock_reset_n_q <= 1'b0;
            bloqueado_q    <= 1'b0;
            aberto_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            falhas_q       <= falhas_d;
            seen_q         <= seen_d;
            insere_out_q   <= insere_out_d;
            lock_reset_n_q <= lock_reset_n_d;
            bloqueado_q    <= bloqueado_d;
            aberto_q       <= aberto_d;
        end
    end

    assign bus.insere_out   = insere_out_q;
    assign bus.lock_reset_n = lock_reset_n_q;
    assign bus.bloqueado    = bloqueado_q;
    assign bus.aberto       = aberto_q;
    assign bus.falhas       = falhas_q;
endmodule
